mmul_parallel_ctrl_fsm: RTL and testbench

MMUL_PARALLEL_CTRL_FSM -- requirements
Module: mmul_parallel_ctrl_fsm

---
 rtl/mmul_parallel_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_mmul_parallel_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_parallel_ctrl_fsm.sv
// Job sequencer for the parallel matrix-multiply engine: arms streamers, starts the
// engine, tracks the output-handshake count and aborts stalled jobs via a watchdog.
//
// state | meaning
// IDLE  | waiting for a trigger
// ARM   | job accepted, waiting for streamers and engine to be ready
// RUN   | engine running, waiting for the output count to reach n_out
// DRAIN | count reached, waiting for the engine to go idle
// FIN   | one-cycle completion: done event plus engine clear
module mmul_parallel_ctrl_fsm #(
    parameter int CNT_W  = 32,
    parameter int WDOG_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              trigger_i,
    input  logic [CNT_W-1:0]  n_out_i,
    input  logic [WDOG_W-1:0] wdog_limit_i,
    input  logic              strm_ready_i,
    input  logic              eng_ready_i,
    input  logic              eng_idle_i,
    input  logic              eng_done_i,
    input  logic [CNT_W-1:0]  eng_cnt_out_i,
    output logic              eng_start_o,
    output logic              eng_clear_o,
    output logic              busy_o,
    output logic              evt_done_o,
    output logic              evt_err_o,
    output logic [2:0]        state_o,
    output logic              done_seen_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_n_out;
    logic [CNT_W-1:0]   r_cnt_prev;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_done_seen;

    logic               w_active;
    logic               w_wdog_hit;
    logic               w_arm_go;
    logic [WDOG_W-1:0]  w_wdog_next;

    assign w_active   = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_wdog_hit = w_active && (wdog_limit_i != '0) && (r_wdog == wdog_limit_i);
    assign w_arm_go   = (r_state == S_ARM) && strm_ready_i && eng_ready_i;

    // Any movement of the engine count means progress, so the stall timer restarts.
    assign w_wdog_next = (eng_cnt_out_i != r_cnt_prev) ? '0 :
                         (&r_wdog)                     ? r_wdog :
                                                         r_wdog + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_n_out     <= '0;
            r_cnt_prev  <= '0;
            r_wdog      <= '0;
            r_done_seen <= 1'b0;
        end else begin
            r_cnt_prev <= eng_cnt_out_i;
            if (eng_done_i) begin
                r_done_seen <= 1'b1;
            end
            if (clear_i) begin
                r_state     <= S_IDLE;
                r_n_out     <= '0;
                r_wdog      <= '0;
                r_done_seen <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_wdog <= '0;
                        if (trigger_i) begin
                            if (n_out_i != '0) begin
                                r_n_out <= n_out_i;
                                r_state <= S_ARM;
                            end else begin
                                r_state <= S_FIN;
                            end
                        end
                    end
                    S_ARM, S_RUN, S_DRAIN: begin
                        r_wdog <= w_wdog_next;
                        if (w_wdog_hit) begin
                            r_state <= S_IDLE;
                            r_wdog  <= '0;
                        end else if (r_state == S_ARM) begin
                            if (w_arm_go) begin
                                r_state <= S_RUN;
                            end
                        end else if (r_state == S_RUN) begin
                            if (eng_cnt_out_i >= r_n_out) begin
                                r_state <= S_DRAIN;
                            end
                        end else if (eng_idle_i) begin
                            r_state <= S_FIN;
                        end
                    end
                    S_FIN: begin
                        r_wdog  <= '0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_wdog  <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // An abort or soft clear in the arming cycle must not also launch the engine.
    assign eng_start_o = w_arm_go && !w_wdog_hit && !clear_i;
    assign evt_done_o  = (r_state == S_FIN) && !clear_i;
    assign evt_err_o   = w_wdog_hit && !clear_i;
    assign eng_clear_o = !rst_i && (clear_i || (r_state == S_FIN) || w_wdog_hit);
    assign busy_o      = (r_state != S_IDLE);
    assign state_o     = r_state;
    assign done_seen_o = r_done_seen;

endmodule

// File: tb/tb_mmul_parallel_ctrl_fsm.sv
// Self-checking bench for mmul_parallel_ctrl_fsm: expected start/done/err events are
// queued with their cycle when stimulus is driven and matched as the DUT emits them.
module tb_mmul_parallel_ctrl_fsm;

    localparam int CNT_W  = 32;
    localparam int WDOG_W = 16;
    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int cyc;
        int kind;
    } evt_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              clear_i;
    logic              trigger_i;
    logic [CNT_W-1:0]  n_out_i;
    logic [WDOG_W-1:0] wdog_limit_i;
    logic              strm_ready_i;
    logic              eng_ready_i;
    logic              eng_idle_i;
    logic              eng_done_i;
    logic [CNT_W-1:0]  eng_cnt_out_i;
    logic              eng_start_o;
    logic              eng_clear_o;
    logic              busy_o;
    logic              evt_done_o;
    logic              evt_err_o;
    logic [2:0]        state_o;
    logic              done_seen_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    evt_t sb_q[$];
    int   t0;
    int   tc;

    mmul_parallel_ctrl_fsm #(.CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trigger_i(trigger_i),
        .n_out_i(n_out_i), .wdog_limit_i(wdog_limit_i), .strm_ready_i(strm_ready_i),
        .eng_ready_i(eng_ready_i), .eng_idle_i(eng_idle_i), .eng_done_i(eng_done_i),
        .eng_cnt_out_i(eng_cnt_out_i), .eng_start_o(eng_start_o), .eng_clear_o(eng_clear_o),
        .busy_o(busy_o), .evt_done_o(evt_done_o), .evt_err_o(evt_err_o),
        .state_o(state_o), .done_seen_o(done_seen_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int c, input int k);
        evt_t e;
        e.cyc  = c;
        e.kind = k;
        sb_q.push_back(e);
    endtask

    task automatic got_evt(input int k);
        evt_t e;
        if (sb_q.size() == 0) begin
            chk("sb_unexpected_kind", k, 255);
        end else begin
            e = sb_q.pop_front();
            chk("sb_kind", k, e.kind);
            chk("sb_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (eng_start_o) got_evt(K_START);
            if (evt_done_o)  got_evt(K_DONE);
            if (evt_err_o)   got_evt(K_ERR);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; trigger_i = 1'b0; n_out_i = '0;
        wdog_limit_i = '0; strm_ready_i = 1'b1; eng_ready_i = 1'b1;
        eng_idle_i = 1'b0; eng_done_i = 1'b0; eng_cnt_out_i = '0;

        // reset state
        tick(); tick();
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", eng_start_o, 0);
        chk("rst_clear", eng_clear_o, 0);
        chk("rst_done", evt_done_o, 0);
        chk("rst_err", evt_err_o, 0);
        rst_i = 1'b0;

        // sticky done capture and soft clear of it
        tick(); eng_done_i = 1'b1;
        tick(); eng_done_i = 1'b0;
        #1 chk("done_seen_set", done_seen_o, 1);
        tick(); clear_i = 1'b1;
        #1 chk("clear_idle_pulse", eng_clear_o, 1);
        tick(); clear_i = 1'b0;
        #1 chk("done_seen_clr", done_seen_o, 0);

        // nominal: n_out = 16
        tick(); trigger_i = 1'b1; n_out_i = 16; t0 = cyc;
        expect_evt(t0 + 1, K_START);
        tick(); trigger_i = 1'b0; n_out_i = 5;
        #1 chk("nom_arm", state_o, 1);
        chk("nom_busy", busy_o, 1);
        tick();
        #1 chk("nom_run", state_o, 2);
        for (int i = 1; i <= 16; i++) begin
            tick();
            eng_cnt_out_i = i;
            if (i == 16) begin
                eng_idle_i = 1'b1;
                tc = cyc;
                expect_evt(tc + 2, K_DONE);
            end else begin
                #1 chk("nom_run_hold", state_o, 2);
            end
        end
        tick();
        #1 chk("nom_drain", state_o, 3);
        tick();
        #1 chk("nom_fin_done", evt_done_o, 1);
        chk("nom_fin_clear", eng_clear_o, 1);
        tick();
        idle_checks("nom_end");
        eng_idle_i = 1'b0; eng_cnt_out_i = '0;

        // zero-length job
        tick(); trigger_i = 1'b1; n_out_i = 0; t0 = cyc;
        expect_evt(t0 + 1, K_DONE);
        tick(); trigger_i = 1'b0;
        #1 chk("zero_fin", state_o, 4);
        chk("zero_nostart", eng_start_o, 0);
        tick();
        idle_checks("zero_end");

        // back-pressure: streamers not ready for 5 cycles
        strm_ready_i = 1'b0;
        tick(); trigger_i = 1'b1; n_out_i = 4; t0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            tick(); trigger_i = 1'b0;
            #1 chk("bp_arm_hold", state_o, 1);
            chk("bp_nostart", eng_start_o, 0);
        end
        tick(); strm_ready_i = 1'b1;
        expect_evt(cyc, K_START);
        #1 chk("bp_start", eng_start_o, 1);
        tick();
        #1 chk("bp_run", state_o, 2);
        tick(); eng_cnt_out_i = 4; eng_idle_i = 1'b1; tc = cyc;
        expect_evt(tc + 2, K_DONE);
        tick(); tick(); tick();
        idle_checks("bp_end");
        eng_idle_i = 1'b0; eng_cnt_out_i = '0;

        // stall: count frozen, watchdog limit 8
        wdog_limit_i = 8;
        tick(); tick();
        tick(); trigger_i = 1'b1; n_out_i = 16; t0 = cyc;
        expect_evt(t0 + 1, K_START);
        expect_evt(t0 + 9, K_ERR);
        tick(); trigger_i = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            #1 chk("stall_noerr", evt_err_o, 0);
        end
        tick();
        #1 chk("stall_err", evt_err_o, 1);
        chk("stall_clear", eng_clear_o, 1);
        tick();
        idle_checks("stall_end");

        // slow progress keeps watchdog quiet, then soft clear aborts in RUN
        tick(); trigger_i = 1'b1; n_out_i = 16; t0 = cyc;
        expect_evt(t0 + 1, K_START);
        tick(); trigger_i = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 0; k < 5; k++) tick();
            eng_cnt_out_i = r;
        end
        #1 chk("slow_run", state_o, 2);
        tick(); clear_i = 1'b1;
        #1 chk("clr_pulse", eng_clear_o, 1);
        chk("clr_nodone", evt_done_o, 0);
        chk("clr_noerr", evt_err_o, 0);
        tick(); clear_i = 1'b0;
        idle_checks("clr_end");
        wdog_limit_i = '0; eng_cnt_out_i = '0;

        // reset asserted while in DRAIN
        tick(); trigger_i = 1'b1; n_out_i = 2; t0 = cyc;
        expect_evt(t0 + 1, K_START);
        tick(); trigger_i = 1'b0;
        tick(); eng_cnt_out_i = 2;
        tick();
        #1 chk("rd_drain", state_o, 3);
        #2 rst_i = 1'b1;
        #1 chk("rd_state", state_o, 0);
        chk("rd_busy", busy_o, 0);
        chk("rd_clear", eng_clear_o, 0);
        chk("rd_done", evt_done_o, 0);
        chk("rd_err", evt_err_o, 0);
        chk("rd_start", eng_start_o, 0);
        tick(); rst_i = 1'b0; eng_idle_i = 1'b1;
        tick(); tick(); tick();
        idle_checks("rd_end");

        tick(); tick();
        chk("sb_leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
